pipe_stage_skid: RTL and testbench

//  Generic, parametrised inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) with valid/ready handshake.

---
 rtl/pipe_pkg.sv | 15 +
 rtl/pipe_stage_skid_if.sv | 13 +
 rtl/pipe_sat_counter.sv | 27 ++
 rtl/pipe_stage_skid.sv | 160 ++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and helpers for the skid pipeline stage
package pipe_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    // All-ones value of a w-bit counter, used as the saturation ceiling.
    function automatic logic [63:0] cnt_sat(input int unsigned w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// rtl/pipe_stage_skid_if.sv - valid/ready beat interface between pipeline stages
interface pipe_stage_skid_if #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 128
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input ready);
    modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - saturating event counter
module pipe_sat_counter
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    localparam logic [CNT_W-1:0] SAT = CNT_W'(cnt_sat(CNT_W));

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != SAT)) count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - inter-stage pipeline register with killable ctrl bits
// and optional 2-entry skid buffer; saturating stall/bubble perf counters.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 128,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    pipe_stage_skid_if.slave    up,
    pipe_stage_skid_if.master   dn,
    output logic [1:0]          occupancy,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    bubble_cnt
);
    logic              dn_valid;
    logic              up_ready;
    logic              push;
    logic              pop;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;

    assign push = up.valid & up_ready & ~flush;
    assign pop  = dn_valid & dn.ready;

    generate
        if (SKID != 0) begin : g_skid
            occ_e              state_q, state_d;
            logic              up_ready_q;
            logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
            logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;

            // Flush only moves the state; data registers keep their stale contents.
            always_comb begin
                state_d     = state_q;
                main_ctrl_d = main_ctrl_q;
                main_data_d = main_data_q;
                skid_ctrl_d = skid_ctrl_q;
                skid_data_d = skid_data_q;
                if (flush) begin
                    state_d = OCC_EMPTY;
                end else begin
                    case (state_q)
                        OCC_EMPTY: begin
                            if (push) begin
                                state_d     = OCC_ONE;
                                main_ctrl_d = up.ctrl;
                                main_data_d = up.data;
                            end
                        end
                        OCC_ONE: begin
                            if (push && pop) begin
                                main_ctrl_d = up.ctrl;
                                main_data_d = up.data;
                            end else if (push) begin
                                state_d     = OCC_TWO;
                                skid_ctrl_d = up.ctrl;
                                skid_data_d = up.data;
                            end else if (pop) begin
                                state_d = OCC_EMPTY;
                            end
                        end
                        OCC_TWO: begin
                            if (pop) begin
                                state_d     = OCC_ONE;
                                main_ctrl_d = skid_ctrl_q;
                                main_data_d = skid_data_q;
                            end
                        end
                        default: state_d = OCC_EMPTY;
                    endcase
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q     <= OCC_EMPTY;
                    up_ready_q  <= 1'b1;
                    main_ctrl_q <= '0;
                    main_data_q <= '0;
                    skid_ctrl_q <= '0;
                    skid_data_q <= '0;
                end else begin
                    state_q     <= state_d;
                    up_ready_q  <= (state_d != OCC_TWO);
                    main_ctrl_q <= main_ctrl_d;
                    main_data_q <= main_data_d;
                    skid_ctrl_q <= skid_ctrl_d;
                    skid_data_q <= skid_data_d;
                end
            end

            assign up_ready  = up_ready_q;
            assign dn_valid  = (state_q != OCC_EMPTY);
            assign occupancy = state_q;
            assign main_ctrl = main_ctrl_q;
            assign main_data = main_data_q;
        end else begin : g_single
            logic              valid_q, valid_d;
            logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
            logic [DATA_W-1:0] main_data_q, main_data_d;

            always_comb begin
                valid_d     = valid_q;
                main_ctrl_d = main_ctrl_q;
                main_data_d = main_data_q;
                if (flush) begin
                    valid_d = 1'b0;
                end else if (push) begin
                    valid_d     = 1'b1;
                    main_ctrl_d = up.ctrl;
                    main_data_d = up.data;
                end else if (pop) begin
                    valid_d = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q     <= 1'b0;
                    main_ctrl_q <= '0;
                    main_data_q <= '0;
                end else begin
                    valid_q     <= valid_d;
                    main_ctrl_q <= main_ctrl_d;
                    main_data_q <= main_data_d;
                end
            end

            assign up_ready  = ~valid_q | dn.ready;
            assign dn_valid  = valid_q;
            assign occupancy = {1'b0, valid_q};
            assign main_ctrl = main_ctrl_q;
            assign main_data = main_data_q;
        end
    endgenerate

    assign up.ready = up_ready;
    assign dn.valid = dn_valid;
    assign dn.ctrl  = main_ctrl & {CTRL_W{dn_valid}};
    assign dn.data  = main_data;

    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (dn_valid & ~dn.ready),
        .count (stall_cnt)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~dn_valid & dn.ready),
        .count (bubble_cnt)
    );
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - directed bench for skid (SKID=1) and single-register (SKID=0) stages
module tb_pipe_stage_skid;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fl1 = 1'b0;
    logic        fl0 = 1'b0;
    logic [1:0]  occ1, occ0;
    logic [15:0] st1, bb1;
    logic [3:0]  st0, bb0;

    int total = 0;
    int bad   = 0;

    pipe_stage_skid_if #(.CTRL_W(16), .DATA_W(128)) up1 ();
    pipe_stage_skid_if #(.CTRL_W(16), .DATA_W(128)) dn1 ();
    pipe_stage_skid_if #(.CTRL_W(16), .DATA_W(128)) up0 ();
    pipe_stage_skid_if #(.CTRL_W(16), .DATA_W(128)) dn0 ();

    pipe_stage_skid #(.CTRL_W(16), .DATA_W(128), .SKID(1), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .flush(fl1), .up(up1), .dn(dn1),
        .occupancy(occ1), .stall_cnt(st1), .bubble_cnt(bb1)
    );

    pipe_stage_skid #(.CTRL_W(16), .DATA_W(128), .SKID(0), .CNT_W(4)) u0 (
        .clk(clk), .rst_n(rst_n), .flush(fl0), .up(up0), .dn(dn0),
        .occupancy(occ0), .stall_cnt(st0), .bubble_cnt(bb0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        uv;
        logic [15:0] c;
        logic        dr;
        logic        fl;
        logic        dv;
        logic [15:0] dc;
        logic [15:0] dd;
        logic [1:0]  occ;
        logic        ur;
        int          stall;
    } vec_t;

    vec_t tv [18];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic uv, input logic [15:0] c, input logic dr, input logic fl);
        up1.valid = uv; up1.ctrl = c; up1.data = {8{c}}; dn1.ready = dr; fl1 = fl;
    endtask

    task automatic drive0(input logic uv, input logic [15:0] c, input logic dr, input logic fl);
        up0.valid = uv; up0.ctrl = c; up0.data = {8{c}}; dn0.ready = dr; fl0 = fl;
    endtask

    initial begin
        // Skid stage starts EMPTY; backpressure, release, then flush in TWO and in ONE.
        tv[0]  = '{1'b1, 16'h00A1, 1'b1, 1'b0, 1'b1, 16'h00A1, 16'h00A1, 2'd1, 1'b1, 0};
        tv[1]  = '{1'b1, 16'h00A2, 1'b0, 1'b0, 1'b1, 16'h00A1, 16'h00A1, 2'd2, 1'b0, 1};
        tv[2]  = '{1'b1, 16'h00A3, 1'b0, 1'b0, 1'b1, 16'h00A1, 16'h00A1, 2'd2, 1'b0, 2};
        tv[3]  = '{1'b1, 16'h00A3, 1'b0, 1'b0, 1'b1, 16'h00A1, 16'h00A1, 2'd2, 1'b0, 3};
        tv[4]  = '{1'b1, 16'h00A3, 1'b0, 1'b0, 1'b1, 16'h00A1, 16'h00A1, 2'd2, 1'b0, 4};
        tv[5]  = '{1'b1, 16'h00A3, 1'b0, 1'b0, 1'b1, 16'h00A1, 16'h00A1, 2'd2, 1'b0, 5};
        tv[6]  = '{1'b1, 16'h00A3, 1'b1, 1'b0, 1'b1, 16'h00A2, 16'h00A2, 2'd1, 1'b1, 5};
        tv[7]  = '{1'b1, 16'h00A3, 1'b1, 1'b0, 1'b1, 16'h00A3, 16'h00A3, 2'd1, 1'b1, 5};
        tv[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h00A3, 2'd0, 1'b1, 5};
        tv[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h00A3, 2'd0, 1'b1, 5};
        tv[10] = '{1'b1, 16'h00B1, 1'b0, 1'b0, 1'b1, 16'h00B1, 16'h00B1, 2'd1, 1'b1, 5};
        tv[11] = '{1'b1, 16'h00B2, 1'b0, 1'b0, 1'b1, 16'h00B1, 16'h00B1, 2'd2, 1'b0, 6};
        tv[12] = '{1'b1, 16'h00B3, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h00B1, 2'd0, 1'b1, 7};
        tv[13] = '{1'b1, 16'h00B4, 1'b1, 1'b0, 1'b1, 16'h00B4, 16'h00B4, 2'd1, 1'b1, 7};
        tv[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h00B4, 2'd0, 1'b1, 7};
        tv[15] = '{1'b1, 16'h00C1, 1'b1, 1'b0, 1'b1, 16'h00C1, 16'h00C1, 2'd1, 1'b1, 7};
        tv[16] = '{1'b1, 16'h00C2, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h00C1, 2'd0, 1'b1, 7};
        tv[17] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h00C1, 2'd0, 1'b1, 7};

        drive1(1'b0, 16'h0, 1'b0, 1'b0);
        drive0(1'b0, 16'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) step();
        chk("rst_dv1", dn1.valid, 1'b0);
        chk("rst_dc1", dn1.ctrl, 16'h0);
        chk("rst_dd1", dn1.data, 128'h0);
        chk("rst_occ1", occ1, 2'd0);
        chk("rst_ur1", up1.ready, 1'b1);
        chk("rst_st1", st1, 16'd0);
        chk("rst_ur0", up0.ready, 1'b1);
        chk("rst_dv0", dn0.valid, 1'b0);
        rst_n = 1'b1;
        step();

        // Streaming with no backpressure: one-cycle latency, strict order.
        for (int i = 0; i < 16; i++) begin
            drive1(1'b1, 16'(i + 1), 1'b1, 1'b0);
            step();
            chk("stream_dv", dn1.valid, 1'b1);
            chk("stream_ctrl", dn1.ctrl, 16'(i + 1));
            chk("stream_data", dn1.data, {8{16'(i + 1)}});
        end
        chk("stream_stall", st1, 16'd0);
        drive1(1'b0, 16'h0, 1'b1, 1'b0);
        step();
        chk("stream_drain", dn1.valid, 1'b0);

        // Asynchronous reset while two beats are held.
        drive1(1'b1, 16'h00E1, 1'b0, 1'b0);
        step();
        drive1(1'b1, 16'h00E2, 1'b0, 1'b0);
        step();
        chk("pre_rst_occ", occ1, 2'd2);
        rst_n = 1'b0;
        #1;
        chk("arst_dv", dn1.valid, 1'b0);
        chk("arst_dc", dn1.ctrl, 16'h0);
        chk("arst_dd", dn1.data, 128'h0);
        chk("arst_occ", occ1, 2'd0);
        chk("arst_ur", up1.ready, 1'b1);
        chk("arst_st", st1, 16'd0);
        drive1(1'b0, 16'h0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_dv", dn1.valid, 1'b0);
        chk("post_rst_occ", occ1, 2'd0);

        for (int i = 0; i < 18; i++) begin
            drive1(tv[i].uv, tv[i].c, tv[i].dr, tv[i].fl);
            step();
            chk($sformatf("tv%0d_dv", i), dn1.valid, tv[i].dv);
            chk($sformatf("tv%0d_dc", i), dn1.ctrl, tv[i].dc);
            chk($sformatf("tv%0d_dd", i), dn1.data, {8{tv[i].dd}});
            chk($sformatf("tv%0d_occ", i), occ1, tv[i].occ);
            chk($sformatf("tv%0d_ur", i), up1.ready, tv[i].ur);
            chk($sformatf("tv%0d_stall", i), st1, 16'(tv[i].stall));
        end
        drive1(1'b0, 16'h0, 1'b0, 1'b0);

        // Single-register stage: combinational up_ready, hold under stall, flush.
        drive0(1'b1, 16'h00D1, 1'b1, 1'b0);
        #1;
        chk("s0_ur_idle", up0.ready, 1'b1);
        step();
        chk("s0_dv1", dn0.valid, 1'b1);
        chk("s0_dc1", dn0.ctrl, 16'h00D1);
        drive0(1'b1, 16'h00D2, 1'b0, 1'b0);
        #1;
        chk("s0_ur_stall", up0.ready, 1'b0);
        step();
        chk("s0_hold_dc", dn0.ctrl, 16'h00D1);
        chk("s0_hold_dd", dn0.data, {8{16'h00D1}});
        step();
        chk("s0_hold_dd2", dn0.data, {8{16'h00D1}});
        chk("s0_hold_occ", occ0, 2'd1);
        drive0(1'b1, 16'h00D2, 1'b1, 1'b0);
        #1;
        chk("s0_ur_release", up0.ready, 1'b1);
        step();
        chk("s0_dv2", dn0.valid, 1'b1);
        chk("s0_dc2", dn0.ctrl, 16'h00D2);
        drive0(1'b0, 16'h0, 1'b1, 1'b0);
        step();
        chk("s0_empty_dv", dn0.valid, 1'b0);
        chk("s0_empty_dc", dn0.ctrl, 16'h0);
        chk("s0_stale_dd", dn0.data, {8{16'h00D2}});
        chk("s0_empty_occ", occ0, 2'd0);
        drive0(1'b1, 16'h00D3, 1'b0, 1'b0);
        step();
        chk("s0_dc3", dn0.ctrl, 16'h00D3);
        drive0(1'b1, 16'h00D4, 1'b0, 1'b1);
        step();
        chk("s0_flush_dv", dn0.valid, 1'b0);
        chk("s0_flush_dc", dn0.ctrl, 16'h0);
        chk("s0_flush_occ", occ0, 2'd0);
        drive0(1'b0, 16'h0, 1'b1, 1'b0);
        step();
        chk("s0_dropped_dv", dn0.valid, 1'b0);
        chk("s0_dropped_dd", dn0.data, {8{16'h00D3}});

        // 4-bit bubble counter saturates at 4'hF.
        drive0(1'b0, 16'h0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("sat_rst", bb0, 4'h0);
        step();
        rst_n = 1'b1;
        repeat (14) step();
        chk("sat_14", bb0, 4'hE);
        repeat (20) step();
        chk("sat_ceiling", bb0, 4'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
